if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_field_reg.sv | 38 +++
 rtl/if_id_stage.sv | 149 ++++++++++++++
 tb/tb_if_id_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the bubble encoding and the
// per-edge update cause used by pipeline stage registers.
package pipe_pkg;

  localparam int          DEF_PC_W      = 16;
  localparam int          DEF_INSTR_W   = 16;
  localparam int          DEF_CNT_W     = 16;
  localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    CAUSE_LOAD   = 3'd0,
    CAUSE_HOLD   = 3'd1,
    CAUSE_FLUSH  = 3'd2,
    CAUSE_FREEZE = 3'd3,
    CAUSE_RESET  = 3'd4
  } cause_e;

  // Only a load takes new data from the upstream stage.
  function automatic logic cause_loads(input cause_e cause);
    return (cause == CAUSE_LOAD);
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline-register field: synchronous reset value, load enable and a
// bubble load that overrides the enable with a fixed encoding.
module pipe_field_reg #(
  parameter int           W          = 1,
  parameter logic [W-1:0] RST_VAL    = '0,
  parameter logic [W-1:0] BUBBLE_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bubble) begin
      q_d = BUBBLE_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with hold, flush-to-NOP and halt freeze.
// Define IF_ID_PERF_EN to add saturating stall/flush event counters.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = DEF_PC_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_add_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               valid_in,
  input  logic               HALT_in,
  input  logic               stall,
  input  logic               flush,
  output logic [PC_W-1:0]    pc_add_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic               HALT_out
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  cause_e cause;
  logic   frozen;
  logic   field_rst;
  logic   load_en;
  logic   flush_kill;
  logic   slot_bubble;

  // A valid halt word stays put until flush or reset retires it.
  assign frozen = valid_out & HALT_out;

  always_comb begin
    cause = CAUSE_LOAD;
    if (rst) begin
      cause = CAUSE_RESET;
    end else if (flush) begin
      cause = CAUSE_FLUSH;
    end else if (frozen) begin
      cause = CAUSE_FREEZE;
    end else if (stall) begin
      cause = CAUSE_HOLD;
    end
  end

  always_comb begin
    field_rst   = (cause == CAUSE_RESET);
    load_en     = cause_loads(cause);
    flush_kill  = (cause == CAUSE_FLUSH);
    // An empty fetch slot loads as a bubble so valid=0 always carries a NOP.
    slot_bubble = flush_kill | (load_en & ~valid_in);
  end

  // The PC is kept across a flush; only a load or reset changes it.
  pipe_field_reg #(
    .W          (PC_W),
    .RST_VAL    ('0),
    .BUBBLE_VAL ('0)
  ) u_pc (
    .clk    (clk),
    .rst    (field_rst),
    .en     (load_en),
    .bubble (1'b0),
    .d      (pc_add_in),
    .q      (pc_add_out)
  );

  pipe_field_reg #(
    .W          (INSTR_W),
    .RST_VAL    (NOP_INSTR),
    .BUBBLE_VAL (NOP_INSTR)
  ) u_instr (
    .clk    (clk),
    .rst    (field_rst),
    .en     (load_en),
    .bubble (slot_bubble),
    .d      (instr_in),
    .q      (instr_out)
  );

  pipe_field_reg #(
    .W          (1),
    .RST_VAL    (1'b0),
    .BUBBLE_VAL (1'b0)
  ) u_valid (
    .clk    (clk),
    .rst    (field_rst),
    .en     (load_en),
    .bubble (flush_kill),
    .d      (valid_in),
    .q      (valid_out)
  );

  pipe_field_reg #(
    .W          (1),
    .RST_VAL    (1'b0),
    .BUBBLE_VAL (1'b0)
  ) u_halt (
    .clk    (clk),
    .rst    (field_rst),
    .en     (load_en),
    .bubble (slot_bubble),
    .d      (HALT_in),
    .q      (HALT_out)
  );

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Counters track the raw requests, so a stall during a freeze still counts.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end else if (stall) begin
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a random run
// against a behavioural model of the stage rules.
module tb_if_id_stage;
  import pipe_pkg::*;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
`ifdef IF_ID_PERF_EN
  localparam int CNT_W   = 8;
`else
  localparam int CNT_W   = 16;
`endif
  localparam logic [INSTR_W-1:0] NOP     = 16'h0800;
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  logic               clk;
  logic               rst;
  logic [PC_W-1:0]    pc_add_in;
  logic [INSTR_W-1:0] instr_in;
  logic               valid_in;
  logic               HALT_in;
  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    pc_add_out;
  logic [INSTR_W-1:0] instr_out;
  logic               valid_out;
  logic               HALT_out;
`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
`endif

  if_id_stage #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_add_in  (pc_add_in),
    .instr_in   (instr_in),
    .valid_in   (valid_in),
    .HALT_in    (HALT_in),
    .stall      (stall),
    .flush      (flush),
    .pc_add_out (pc_add_out),
    .instr_out  (instr_out),
    .valid_out  (valid_out),
    .HALT_out   (HALT_out)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model of the stage contents
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic               m_valid;
  logic               m_halt;
  logic [CNT_W-1:0]   m_stall_cnt;
  logic [CNT_W-1:0]   m_flush_cnt;

  task automatic drive(input logic r, input logic f, input logic s,
                       input logic v, input logic h,
                       input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    rst = r; flush = f; stall = s; valid_in = v; HALT_in = h;
    pc_add_in = pc; instr_in = ins;
  endtask

  // Advance one edge and apply the stage rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
      m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      if (flush && m_flush_cnt != CNT_MAX) m_flush_cnt = m_flush_cnt + 1'b1;
      if (!flush && stall && m_stall_cnt != CNT_MAX) m_stall_cnt = m_stall_cnt + 1'b1;
      if (flush) begin
        m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
      end else if (m_valid && m_halt) begin
        // frozen on a halt word
      end else if (stall) begin
        // hold
      end else begin
        m_pc    = pc_add_in;
        m_valid = valid_in;
        m_instr = valid_in ? instr_in : NOP;
        m_halt  = valid_in ? HALT_in : 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0000, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%h instr=%h v=%b h=%b want 0000/0800/0/0",
               pc_add_out, instr_out, valid_out, HALT_out);
    end
`ifdef IF_ID_PERF_EN
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%h flush=%h want 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_load();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h1234);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0012, 16'h1234, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load: got pc=%h instr=%h v=%b h=%b want 0012/1234/1/0",
               pc_add_out, instr_out, valid_out, HALT_out);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'(16'h0100 + i), 16'(16'h7700 + i));
      step();
      checks++;
      if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0012, 16'h1234, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got pc=%h instr=%h v=%b want 0012/1234/1",
                 i, pc_add_out, instr_out, valid_out);
      end
    end
`ifdef IF_ID_PERF_EN
    checks++;
    if (stall_cnt !== CNT_W'(3)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_flush_with_stall();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0ABC, 16'h4321);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0012, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_stall: got pc=%h instr=%h v=%b h=%b want 0012/0800/0/0",
               pc_add_out, instr_out, valid_out, HALT_out);
    end
`ifdef IF_ID_PERF_EN
    checks++;
    if (flush_cnt !== CNT_W'(1) || stall_cnt !== CNT_W'(3)) begin
      errors++;
      $display("FAIL flush_stall_cnt: got flush=%0d stall=%0d want 1/3", flush_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_bubble_load();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0024, 16'hBEEF);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0024, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bubble_load: got pc=%h instr=%h v=%b h=%b want 0024/0800/0/0",
               pc_add_out, instr_out, valid_out, HALT_out);
    end
  endtask

  task automatic test_halt_freeze();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hF000);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0,
            16'($urandom), 16'($urandom));
      step();
      checks++;
      if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0040, 16'hF000, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL halt_freeze_%0d: got pc=%h instr=%h v=%b h=%b want 0040/f000/1/1",
                 i, pc_add_out, instr_out, valid_out, HALT_out);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0099, 16'h9999);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0040, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_release: got pc=%h instr=%h v=%b h=%b want 0040/0800/0/0",
               pc_add_out, instr_out, valid_out, HALT_out);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0044, 16'h2468);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out} !== {16'h0044, 16'h2468, 1'b1}) begin
      errors++;
      $display("FAIL post_release_load: got pc=%h instr=%h v=%b want 0044/2468/1",
               pc_add_out, instr_out, valid_out);
    end
  endtask

  task automatic test_saturation();
`ifdef IF_ID_PERF_EN
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      step();
    end
    checks++;
    if (stall_cnt !== CNT_MAX) begin
      errors++;
      $display("FAIL stall_saturate: got %h want %h", stall_cnt, CNT_MAX);
    end
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0);
      step();
    end
    checks++;
    if (flush_cnt !== CNT_MAX || stall_cnt !== CNT_MAX) begin
      errors++;
      $display("FAIL flush_saturate: got flush=%h stall=%h want %h/%h",
               flush_cnt, stall_cnt, CNT_MAX, CNT_MAX);
    end
`endif
  endtask

  task automatic test_reset_in_freeze();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0066, 16'hF0F0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0077, 16'h7777);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0088, 16'h8888);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out, HALT_out} !== {16'h0000, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_freeze: got pc=%h instr=%h v=%b h=%b want 0000/0800/0/0",
               pc_add_out, instr_out, valid_out, HALT_out);
    end
`ifdef IF_ID_PERF_EN
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_in_freeze_cnt: got stall=%h flush=%h want 0/0", stall_cnt, flush_cnt);
    end
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1111);
    step();
    checks++;
    if ({pc_add_out, instr_out, valid_out} !== {16'h0010, 16'h1111, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_load: got pc=%h instr=%h v=%b want 0010/1111/1",
               pc_add_out, instr_out, valid_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0), 16'($urandom), 16'($urandom));
      step();
      checks++;
      if ({pc_add_out, instr_out, valid_out, HALT_out} !== {m_pc, m_instr, m_valid, m_halt}) begin
        errors++;
        $display("FAIL random_%0d: got pc=%h instr=%h v=%b h=%b want %h/%h/%b/%b", i,
                 pc_add_out, instr_out, valid_out, HALT_out, m_pc, m_instr, m_valid, m_halt);
      end
      checks++;
      if (!valid_out && (instr_out !== NOP || HALT_out !== 1'b0)) begin
        errors++;
        $display("FAIL invalid_slot_%0d: got instr=%h h=%b want 0800/0", i, instr_out, HALT_out);
      end
`ifdef IF_ID_PERF_EN
      checks++;
      if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
        errors++;
        $display("FAIL random_cnt_%0d: got stall=%h flush=%h want %h/%h", i,
                 stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
      end
`endif
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_load();
    test_stall();
    test_flush_with_stall();
    test_bubble_load();
    test_halt_freeze();
    test_saturation();
    test_reset_in_freeze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
